// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in, serial-out serializer.
// Holds the FSM state encoding and the counter-width helper.
package piso_serializer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Counter width for a frame of `width` bits; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready input and frame strobes.
// Supports back-to-back frames by re-accepting a word in the last bit cycle.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0,
    localparam int unsigned CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             frame_start,
    output logic             frame_done,
    output logic [CNT_W-1:0] bit_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_q, ser_d;
    logic             act_q, act_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             ready_en_q;
    logic             last_bit;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drops the bit just transmitted so first_bit() yields the next one.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
    // ready_en_q holds din_ready low until the first edge after reset release.
    assign din_ready = ready_en_q && ((state_q == ST_IDLE) || last_bit);
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ser_d   = ser_q;
        act_d   = act_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shreg_d = advance(din);
            ser_d   = first_bit(din);
            act_d   = 1'b1;
            start_d = 1'b1;
        end else if (last_bit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            ser_d   = IDLE_LEVEL;
            act_d   = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = advance(shreg_q);
            ser_d   = first_bit(shreg_q);
        end
        done_d = act_d && (cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            ser_q      <= IDLE_LEVEL;
            act_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ser_q      <= ser_d;
            act_q      <= act_d;
            start_q    <= start_d;
            done_q     <= done_d;
            ready_en_q <= 1'b1;
        end
    end

    assign ser_out     = ser_q;
    assign ser_active  = act_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign bit_idx     = cnt_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage upstream of the team's 4-stage serial shift chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on ser_out.
- Supports back-to-back frames with no idle gap.
- Adds framing strobes so downstream logic can align the serial stream.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on ser_out when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept din this cycle.
- ser_out  output  1  serial data bit, registered.
- ser_active  output  1  ser_out carries a data bit this cycle.
- frame_start  output  1  one-cycle pulse coincident with the first bit of a frame.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.
- bit_idx  output  $clog2(WIDTH)  position of the current bit within the frame, 0 = first transmitted.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - State is IDLE.
  - ser_out=IDLE_LEVEL; ser_active=0, frame_start=0, frame_done=0, bit_idx=0.
  - Shift register is cleared.
  - din_ready=0 while reset is asserted, 1 from the first clock edge after release.
- All outputs except din_ready are registered. din_ready is combinational from state and counter.
- States:
  - IDLE: din_ready=1, ser_active=0, ser_out=IDLE_LEVEL.
  - SHIFT: ser_active=1.
- Accept condition: din_valid && din_ready at a rising edge. din is captured into the shift register at that edge and need not stay stable afterwards.
- Latency: the first bit appears on ser_out in the cycle immediately after the accepting edge, with frame_start=1 and bit_idx=0.
- Each bit is held for exactly one cycle; a frame occupies WIDTH consecutive cycles. bit_idx increments by 1 per cycle.
- Bit order:
  - MSB_FIRST=1: din[WIDTH-1] down to din[0].
  - MSB_FIRST=0: din[0] up to din[WIDTH-1].
- In the last bit cycle (bit_idx==WIDTH-1): frame_done=1, and din_ready=1.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT when the last bit completes and a new word is accepted in that same cycle (back-to-back). The next frame's first bit follows with zero gap; frame_start is high in the cycle after frame_done.
  - SHIFT -> IDLE when the last bit completes with no accept.
- din_ready=0 during SHIFT except in the last bit cycle; din_valid is ignored while din_ready=0.
- WIDTH==2: the frame is only first bit plus last bit; frame_start and frame_done fall in consecutive cycles.
- Reset asserted mid-frame: the frame is abandoned immediately. No frame_done is issued and the partial word is discarded.
- The bit counter wraps only via a reload on accept; it never counts past WIDTH-1.

Decomposition:
- Shared package: state enum (IDLE, SHIFT), localparam CNT_W = $clog2(WIDTH).
- No sub-module required. The shift register and counter live inline; the FSM is two states.

Test Plan:
- Reset release, din_valid=0 for 10 cycles -> ser_out=0, ser_active=0, din_ready=1, no strobes.
- WIDTH=4, MSB_FIRST=1, send din=4'b1011 -> next 4 cycles ser_out=1,0,1,1; frame_start in cycle 1, frame_done in cycle 4; then IDLE.
- MSB_FIRST=0, din=4'b1011 -> ser_out=1,1,0,1.
- Back-to-back 4'hA then 4'h5, din_valid held high -> 8 contiguous bits 1,0,1,0,0,1,0,1; ser_active never drops; din_ready high only in idle and in each last-bit cycle.
- Reset asserted during bit 2 of 4'hF -> outputs return to reset values asynchronously, no frame_done; next frame 4'h3 serializes correctly as 0,0,1,1.
- Chained into the 4-stage shift chain: send 4'b1001 -> chain output shows 1,0,0,1 starting 4 cycles after the first ser_out bit.
